fp_addsub_pipe: RTL and testbench

//  Parametrised, handshaked floating-point add/subtract pipeline for the MAC datapath.

---
 rtl/fp_mac_pkg.sv | 24 ++
 rtl/fp_addsub_pipe_if.sv | 41 ++++
 rtl/fp_lzc.sv | 25 ++
 rtl/fp_addsub_pipe.sv | 189 ++++++++++++++++++
 tb/tb_fp_addsub_pipe.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/fp_mac_pkg.sv
// Shared definitions for the MAC datapath floating-point blocks.
//   EXP_W_DEF / MAN_W_DEF : default exponent / stored-mantissa widths
//   OP_ADD / OP_SUB       : encodings of the op_sub control input
//   fp_t                  : {sign, biased exponent, stored fraction} at default widths
//   fp_bias()             : exponent bias for a given exponent width
package fp_mac_pkg;

  localparam int unsigned EXP_W_DEF = 3;
  localparam int unsigned MAN_W_DEF = 2;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  typedef struct packed {
    logic                 sign;
    logic [EXP_W_DEF-1:0] exp;
    logic [MAN_W_DEF-1:0] man;
  } fp_t;

  function automatic int unsigned fp_bias(input int unsigned exp_w);
    return (32'd1 << (exp_w - 1)) - 32'd1;
  endfunction

endpackage

// File: rtl/fp_addsub_pipe_if.sv
// Handshaked operand/result bus of fp_addsub_pipe.
//   Input side : in_valid/in_ready, op_sub, a_*, b_*, in_tag
//   Output side: out_valid/out_ready, res_sign/exp/man, res_ovf, res_unf, out_tag
//   slave  : the add/sub pipeline's view
//   master : the producer/consumer view
interface fp_addsub_pipe_if #(
  parameter int unsigned EXP_W = 3,
  parameter int unsigned MAN_W = 2,
  parameter int unsigned TAG_W = 1
);
  logic             in_valid;
  logic             in_ready;
  logic             op_sub;
  logic             a_sign;
  logic [EXP_W-1:0] a_exp;
  logic [MAN_W-1:0] a_man;
  logic             b_sign;
  logic [EXP_W-1:0] b_exp;
  logic [MAN_W-1:0] b_man;
  logic [TAG_W-1:0] in_tag;

  logic             out_valid;
  logic             out_ready;
  logic             res_sign;
  logic [EXP_W-1:0] res_exp;
  logic [MAN_W-1:0] res_man;
  logic             res_ovf;
  logic             res_unf;
  logic [TAG_W-1:0] out_tag;

  modport slave (
    input  in_valid, op_sub, a_sign, a_exp, a_man, b_sign, b_exp, b_man, in_tag, out_ready,
    output in_ready, out_valid, res_sign, res_exp, res_man, res_ovf, res_unf, out_tag
  );

  modport master (
    output in_valid, op_sub, a_sign, a_exp, a_man, b_sign, b_exp, b_man, in_tag, out_ready,
    input  in_ready, out_valid, res_sign, res_exp, res_man, res_ovf, res_unf, out_tag
  );

endinterface

// File: rtl/fp_lzc.sv
// Parametrised leading-zero counter.
//   din : value to scan, MSB first
//   cnt : number of zeros above the most significant 1 (W when din is 0)
module fp_lzc #(
  parameter int unsigned W  = 5,
  parameter int unsigned CW = $clog2(W + 1)
) (
  input  logic [W-1:0]  din,
  output logic [CW-1:0] cnt
);

  logic found;

  always_comb begin
    cnt   = CW'(W);
    found = 1'b0;
    for (int unsigned i = 0; i < W; i++) begin
      if (!found && din[W-1-i]) begin
        cnt   = CW'(i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fp_addsub_pipe.sv
// Three-stage handshaked floating-point add/subtract pipeline.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : operand/result handshake bus (slave side), see fp_addsub_pipe_if
// S1 aligns (larger magnitude to X, Y shifted right), S2 adds/subtracts magnitudes,
// S3 normalises, saturates on overflow and flushes to +0 on underflow.
module fp_addsub_pipe
  import fp_mac_pkg::*;
#(
  parameter int unsigned EXP_W = EXP_W_DEF,
  parameter int unsigned MAN_W = MAN_W_DEF,
  parameter int unsigned GRD_W = 2,
  parameter int unsigned TAG_W = 1
) (
  input logic             clk,
  input logic             rst_n,
  fp_addsub_pipe_if.slave bus
);

  localparam int unsigned F    = MAN_W + 1 + GRD_W;   // aligned field incl. hidden bit
  localparam int unsigned S    = F + 1;               // sum with carry-out
  localparam int unsigned LZ_W = $clog2(F + 1);
  localparam int unsigned EW   = ((EXP_W > LZ_W) ? EXP_W : LZ_W) + 2;

  localparam logic signed [EW-1:0] E_MAX = EW'((1 << EXP_W) - 1);
  localparam logic signed [EW-1:0] E_MIN = EW'(1);

  // ---------------- handshake ----------------
  logic v1, v2;
  logic en1, en2, en3;

  assign en3          = !bus.out_valid || bus.out_ready;
  assign en2          = !v2 || en3;
  assign en1          = !v1 || en2;
  assign bus.in_ready = en1;

  // ---------------- S1: align ----------------
  logic             b_es, a_ge, xs, sub_eff;
  logic [MAN_W-1:0] am, bm, xm, ym;
  logic [EXP_W-1:0] xe, ye, d;
  logic [F-1:0]     x_f, y_full, y_f;

  always_comb begin
    // A zero operand has its fraction ignored, so mask it before comparing.
    am      = (bus.a_exp != '0) ? bus.a_man : '0;
    bm      = (bus.b_exp != '0) ? bus.b_man : '0;
    b_es    = bus.b_sign ^ (bus.op_sub == OP_SUB);
    sub_eff = bus.a_sign ^ b_es;
    a_ge    = {bus.a_exp, am} >= {bus.b_exp, bm};
    if (a_ge) begin
      xs = bus.a_sign;
      xe = bus.a_exp;
      xm = am;
      ye = bus.b_exp;
      ym = bm;
    end else begin
      xs = b_es;
      xe = bus.b_exp;
      xm = bm;
      ye = bus.a_exp;
      ym = am;
    end
    d      = xe - ye;
    x_f    = {xe != '0, xm, {GRD_W{1'b0}}};
    y_full = {ye != '0, ym, {GRD_W{1'b0}}};
    y_f    = (32'(d) >= F) ? '0 : (y_full >> d);
  end

  logic             s1_sign, s1_sub;
  logic [EXP_W-1:0] s1_exp;
  logic [F-1:0]     s1_x, s1_y;
  logic [TAG_W-1:0] s1_tag;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1      <= 1'b0;
      s1_sign <= 1'b0;
      s1_sub  <= 1'b0;
      s1_exp  <= '0;
      s1_x    <= '0;
      s1_y    <= '0;
      s1_tag  <= '0;
    end else if (en1) begin
      v1 <= bus.in_valid;
      if (bus.in_valid) begin
        s1_sign <= xs;
        s1_sub  <= sub_eff;
        s1_exp  <= xe;
        s1_x    <= x_f;
        s1_y    <= y_f;
        s1_tag  <= bus.in_tag;
      end
    end
  end

  // ---------------- S2: add / subtract ----------------
  logic [S-1:0] sum;

  // X >= Y by construction, so the difference never wraps.
  assign sum = s1_sub ? ({1'b0, s1_x} - {1'b0, s1_y}) : ({1'b0, s1_x} + {1'b0, s1_y});

  logic             s2_sign;
  logic [EXP_W-1:0] s2_exp;
  logic [S-1:0]     s2_sum;
  logic [TAG_W-1:0] s2_tag;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2      <= 1'b0;
      s2_sign <= 1'b0;
      s2_exp  <= '0;
      s2_sum  <= '0;
      s2_tag  <= '0;
    end else if (en2) begin
      v2 <= v1;
      if (v1) begin
        s2_sign <= s1_sign;
        s2_exp  <= s1_exp;
        s2_sum  <= sum;
        s2_tag  <= s1_tag;
      end
    end
  end

  // ---------------- S3: normalise ----------------
  logic                   carry, zero, ovf, unf;
  logic [LZ_W-1:0]        lz;
  logic [F-1:0]           norm;
  logic signed [EW-1:0]   e_n;
  logic                   r_sign, r_ovf, r_unf;
  logic [EXP_W-1:0]       r_exp;
  logic [MAN_W-1:0]       r_man;

  fp_lzc #(.W(F), .CW(LZ_W)) u_lzc (
    .din (s2_sum[F-1:0]),
    .cnt (lz)
  );

  always_comb begin
    carry  = s2_sum[S-1];
    zero   = (s2_sum == '0);
    norm   = carry ? s2_sum[S-1:1] : (s2_sum[F-1:0] << lz);
    e_n    = carry ? $signed(EW'(s2_exp) + EW'(1)) : $signed(EW'(s2_exp) - EW'(lz));
    ovf    = !zero && (e_n > E_MAX);
    unf    = !zero && (e_n < E_MIN);
    r_sign = s2_sign;
    r_exp  = e_n[EXP_W-1:0];
    r_man  = norm[F-2 -: MAN_W];
    r_ovf  = 1'b0;
    r_unf  = 1'b0;
    if (zero) begin
      r_sign = 1'b0;
      r_exp  = '0;
      r_man  = '0;
    end else if (ovf) begin
      r_exp  = '1;
      r_man  = '1;
      r_ovf  = 1'b1;
    end else if (unf) begin
      r_sign = 1'b0;
      r_exp  = '0;
      r_man  = '0;
      r_unf  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.out_valid <= 1'b0;
      bus.res_sign  <= 1'b0;
      bus.res_exp   <= '0;
      bus.res_man   <= '0;
      bus.res_ovf   <= 1'b0;
      bus.res_unf   <= 1'b0;
      bus.out_tag   <= '0;
    end else if (en3) begin
      bus.out_valid <= v2;
      if (v2) begin
        bus.res_sign <= r_sign;
        bus.res_exp  <= r_exp;
        bus.res_man  <= r_man;
        bus.res_ovf  <= r_ovf;
        bus.res_unf  <= r_unf;
        bus.out_tag  <= s2_tag;
      end
    end
  end

endmodule

// File: tb/tb_fp_addsub_pipe.sv
// Directed self-checking bench for fp_addsub_pipe (EXP_W=3, MAN_W=2, GRD_W=2, TAG_W=1).
module tb_fp_addsub_pipe;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  fp_addsub_pipe_if #(.EXP_W(3), .MAN_W(2), .TAG_W(1)) ifc ();

  fp_addsub_pipe #(.EXP_W(3), .MAN_W(2), .GRD_W(2), .TAG_W(1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc)
  );

  typedef struct packed {
    logic       op;
    logic       asg;
    logic [2:0] ae;
    logic [1:0] am;
    logic       bsg;
    logic [2:0] be;
    logic [1:0] bm;
    logic       rs;
    logic [2:0] re;
    logic [1:0] rm;
    logic       ro;
    logic       ru;
  } vec_t;

  vec_t vt [13];

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic vec_t mk(input int op, asg, ae, am, bsg, be, bm, rs, re, rm, ro, ru);
    vec_t v;
    v.op  = 1'(op);
    v.asg = 1'(asg);
    v.ae  = 3'(ae);
    v.am  = 2'(am);
    v.bsg = 1'(bsg);
    v.be  = 3'(be);
    v.bm  = 2'(bm);
    v.rs  = 1'(rs);
    v.re  = 3'(re);
    v.rm  = 2'(rm);
    v.ro  = 1'(ro);
    v.ru  = 1'(ru);
    return v;
  endfunction

  task automatic drive(input int k, input logic v, input logic tag);
    ifc.in_valid = v;
    ifc.op_sub   = vt[k].op;
    ifc.a_sign   = vt[k].asg;
    ifc.a_exp    = vt[k].ae;
    ifc.a_man    = vt[k].am;
    ifc.b_sign   = vt[k].bsg;
    ifc.b_exp    = vt[k].be;
    ifc.b_man    = vt[k].bm;
    ifc.in_tag   = tag;
  endtask

  function automatic logic [8:0] obs();
    return {ifc.res_sign, ifc.res_exp, ifc.res_man, ifc.res_ovf, ifc.res_unf, ifc.out_tag};
  endfunction

  function automatic logic [8:0] want(input int k, input logic tag);
    return {vt[k].rs, vt[k].re, vt[k].rm, vt[k].ro, vt[k].ru, tag};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //            op as ae am bs be bm   rs re rm ov un
    vt[0]  = mk(0, 0, 3, 0, 0, 3, 2,   0, 4, 1, 0, 0);  // 1.0 + 1.5 = 2.5
    vt[1]  = mk(1, 0, 3, 2, 0, 3, 2,   0, 0, 0, 0, 0);  // 1.5 - 1.5 = +0
    vt[2]  = mk(1, 0, 3, 0, 0, 3, 2,   1, 2, 0, 0, 0);  // 1.0 - 1.5 = -0.5
    vt[3]  = mk(0, 0, 7, 3, 0, 7, 3,   0, 7, 3, 1, 0);  // 28 + 28 saturates
    vt[4]  = mk(1, 0, 1, 1, 0, 1, 0,   0, 0, 0, 0, 1);  // underflow
    vt[5]  = mk(0, 0, 5, 0, 0, 1, 3,   0, 5, 0, 0, 0);  // small Y lost in guard bits
    vt[6]  = mk(0, 0, 0, 3, 1, 4, 2,   1, 4, 2, 0, 0);  // zero A (fraction ignored)
    vt[7]  = mk(1, 0, 6, 1, 0, 0, 0,   0, 6, 1, 0, 0);  // A - 0
    vt[8]  = mk(1, 0, 0, 0, 0, 2, 1,   1, 2, 1, 0, 0);  // 0 - B
    vt[9]  = mk(0, 1, 0, 0, 1, 0, 0,   0, 0, 0, 0, 0);  // -0 + -0 = +0
    vt[10] = mk(0, 0, 3, 0, 0, 2, 0,   0, 3, 2, 0, 0);  // 1.0 + 0.5 = 1.5
    vt[11] = mk(0, 1, 4, 1, 0, 3, 0,   1, 3, 2, 0, 0);  // -2.5 + 1.0 = -1.5
    vt[12] = mk(0, 0, 3, 3, 0, 1, 3,   0, 4, 0, 0, 0);  // 1.75 + 0.4375 truncates to 2.0

    drive(0, 1'b0, 1'b0);
    ifc.out_ready = 1'b1;

    // reset state
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_out_valid", 32'(ifc.out_valid), 32'd0);
    check("rst_in_ready", 32'(ifc.in_ready), 32'd1);
    check("rst_res", 32'(obs()), 32'd0);

    // directed single pairs, latency and value
    for (int k = 0; k < 13; k++) begin
      int n;
      @(negedge clk);
      drive(k, 1'b1, k[0]);
      #1;
      check($sformatf("dir%0d_in_ready", k), 32'(ifc.in_ready), 32'd1);
      @(posedge clk);
      @(negedge clk);
      ifc.in_valid = 1'b0;
      n = 1;
      while (!ifc.out_valid && n < 10) begin
        @(posedge clk);
        @(negedge clk);
        n++;
      end
      check($sformatf("dir%0d_lat", k), 32'(n), 32'd3);
      check($sformatf("dir%0d_res", k), 32'(obs()), 32'(want(k, k[0])));
    end

    // back-to-back stream with out_ready pattern 1,0,0,1,0,0...
    begin
      int         sent;
      int         got;
      logic       stalled;
      logic       fin;
      logic [8:0] held;
      sent    = 0;
      got     = 0;
      stalled = 1'b0;
      held    = '0;
      for (int cyc = 0; cyc < 200 && got < 8; cyc++) begin
        @(negedge clk);
        ifc.out_ready = (cyc % 3 == 0);
        if (sent < 8) drive(sent, 1'b1, sent[0]);
        else          ifc.in_valid = 1'b0;
        #1;
        if (stalled) check($sformatf("stall_hold%0d", cyc), 32'(obs()), 32'(held));
        if (ifc.out_valid && ifc.out_ready) begin
          check($sformatf("strm%0d", got), 32'(obs()), 32'(want(got, got[0])));
          got++;
        end
        stalled = ifc.out_valid && !ifc.out_ready;
        held    = obs();
        fin     = ifc.in_valid && ifc.in_ready;
        @(posedge clk);
        if (fin) sent++;
      end
      check("strm_count", 32'(got), 32'd8);
      @(negedge clk);
      ifc.in_valid = 1'b0;
      #1;
      check("strm_drained", 32'(ifc.out_valid), 32'd0);
    end

    // reset with three pairs in flight
    ifc.out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      drive(k, 1'b1, 1'b1);
      @(posedge clk);
    end
    @(negedge clk);
    ifc.in_valid = 1'b0;
    #1;
    check("pre_rst_valid", 32'(ifc.out_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    check("rst_fl_out_valid", 32'(ifc.out_valid), 32'd0);
    check("rst_fl_res", 32'(obs()), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_fl_in_ready", 32'(ifc.in_ready), 32'd1);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      #1;
      check($sformatf("no_stale%0d", c), 32'(ifc.out_valid), 32'd0);
    end

    // pipeline still works after reset
    begin
      int n;
      @(negedge clk);
      drive(11, 1'b1, 1'b0);
      @(posedge clk);
      @(negedge clk);
      ifc.in_valid = 1'b0;
      n = 1;
      while (!ifc.out_valid && n < 10) begin
        @(posedge clk);
        @(negedge clk);
        n++;
      end
      check("post_rst_lat", 32'(n), 32'd3);
      check("post_rst_res", 32'(obs()), 32'(want(11, 1'b0)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
